// File: rtl/mac4_seq.sv
// rtl/mac4_seq.sv - job sequencer around an external 4-bit MAC (out1 = in1*in2 + in3, mod 16)
// Optional abort input enabled by defining MAC4_SEQ_ABORT_EN.
module mac4_seq #(
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [3:0]       acc_init,
   input  logic [3:0]       a_in,
   input  logic [3:0]       b_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [3:0]       mac_in1,
   output logic [3:0]       mac_in2,
   output logic [3:0]       mac_in3,
   input  logic [3:0]       mac_out1,
   output logic [3:0]       res,
   output logic             res_valid,
   input  logic             res_ready,
`ifdef MAC4_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [3:0]       r_acc;
   logic [LEN_W-1:0] r_cnt;
   logic [3:0]       r_res;

   logic w_in_acc;
   logic w_beat;
   logic w_abort;

   assign w_in_acc = (r_state == S_ACC);
   assign w_beat   = w_in_acc & in_valid;

`ifdef MAC4_SEQ_ABORT_EN
   assign w_abort = abort & (r_state != S_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   // Operands go straight to the MAC so the accumulate loop closes in one cycle.
   assign mac_in1   = w_in_acc ? a_in : 4'd0;
   assign mac_in2   = w_in_acc ? b_in : 4'd0;
   assign mac_in3   = r_acc;
   assign in_ready  = w_in_acc;
   assign res_valid = (r_state == S_DONE);
   assign res       = r_res;
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_acc   <= 4'd0;
         r_cnt   <= '0;
         r_res   <= 4'd0;
      end else if (w_abort) begin
         // Abort wins over a same-cycle beat or result handshake; res keeps its old value.
         r_state <= S_IDLE;
         r_acc   <= 4'd0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc   <= acc_init;
                  r_cnt   <= len;
                  r_state <= S_ACC;
               end
            end
            S_ACC: begin
               if (w_beat) begin
                  r_acc <= mac_out1;
                  if (r_cnt == '0) begin
                     r_res   <= mac_out1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt - LEN_W'(1);
                  end
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
